// File: rtl/circle_plotter_param.sv
// Parametrised midpoint-circle plotter driving the VGA adapter write port, with clipping.
// Optional pre-draw screen clear is built when CIRCLE_CLEAR_SCREEN_EN is defined.
module circle_plotter_param #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  input  logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int C_W = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int O_W = R_W + 2;
  localparam int K_W = R_W + 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
`ifdef CIRCLE_CLEAR_SCREEN_EN
  localparam logic [2:0] S_CLEAR  = 3'd1;
`endif
  localparam logic [2:0] S_PLOT   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic signed [O_W-1:0] O_ONE  = O_W'(1);
  localparam logic signed [O_W-1:0] O_ZERO = O_W'(0);
  localparam logic signed [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic signed [K_W-1:0] K_ZERO = K_W'(0);
  localparam logic signed [C_W-1:0] C_ZERO = C_W'(0);
  localparam logic signed [C_W-1:0] C_SW   = C_W'(SCREEN_W);
  localparam logic signed [C_W-1:0] C_SH   = C_W'(SCREEN_H);

  function automatic logic signed [K_W-1:0] to_k(input logic signed [O_W-1:0] v);
    return $signed({v[O_W-1], v});
  endfunction

  function automatic logic signed [C_W-1:0] to_c(input logic signed [O_W-1:0] v);
    return C_W'(v);
  endfunction

  logic [2:0]              state_r, state_nxt_s;
  logic [2:0]              oct_r, oct_nxt_s;
  logic signed [O_W-1:0]   ox_r, ox_nxt_s, oy_r, oy_nxt_s;
  logic signed [K_W-1:0]   crit_r, crit_nxt_s;
  logic [X_W-1:0]          cx_r, cx_nxt_s;
  logic [Y_W-1:0]          cy_r, cy_nxt_s;
  logic [COLOUR_W-1:0]     col_r, col_nxt_s;
`ifdef CIRCLE_CLEAR_SCREEN_EN
  logic [X_W-1:0]          clr_x_r, clr_x_nxt_s;
  logic [Y_W-1:0]          clr_y_r, clr_y_nxt_s;
`endif

  logic signed [O_W-1:0]   upd_ox_s, upd_oy_s;
  logic signed [K_W-1:0]   upd_crit_s;
  logic signed [C_W-1:0]   dx_s, dy_s, px_s, py_s;
  logic                    on_screen_s;
  logic [X_W-1:0]          vx_nxt_s;
  logic [Y_W-1:0]          vy_nxt_s;
  logic [COLOUR_W-1:0]     vc_nxt_s;
  logic                    plot_nxt_s, busy_nxt_s, done_nxt_s;

  // Midpoint step: oy advances every iteration, ox only when the decision is positive
  always_comb begin
    upd_oy_s   = oy_r + O_ONE;
    upd_ox_s   = ox_r;
    upd_crit_s = crit_r;
    if ((crit_r[K_W-1] == 1'b1) || (crit_r == K_ZERO)) begin
      upd_ox_s   = ox_r;
      upd_crit_s = crit_r + (to_k(upd_oy_s) <<< 1) + K_ONE;
    end else begin
      upd_ox_s   = ox_r - O_ONE;
      upd_crit_s = crit_r + (to_k(upd_oy_s - upd_ox_s) <<< 1) + K_ONE;
    end
  end

  // Next-state and next-counter logic
  always_comb begin
    state_nxt_s = state_r;
    oct_nxt_s   = oct_r;
    ox_nxt_s    = ox_r;
    oy_nxt_s    = oy_r;
    crit_nxt_s  = crit_r;
    cx_nxt_s    = cx_r;
    cy_nxt_s    = cy_r;
    col_nxt_s   = col_r;
`ifdef CIRCLE_CLEAR_SCREEN_EN
    clr_x_nxt_s = clr_x_r;
    clr_y_nxt_s = clr_y_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (start) begin
          cx_nxt_s   = centre_x;
          cy_nxt_s   = centre_y;
          col_nxt_s  = colour;
          ox_nxt_s   = $signed({2'b00, radius});
          oy_nxt_s   = O_ZERO;
          crit_nxt_s = K_ONE - $signed({3'b000, radius});
          oct_nxt_s  = 3'd0;
`ifdef CIRCLE_CLEAR_SCREEN_EN
          clr_x_nxt_s = {X_W{1'b0}};
          clr_y_nxt_s = {Y_W{1'b0}};
          state_nxt_s = S_CLEAR;
`else
          state_nxt_s = S_PLOT;
`endif
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
`ifdef CIRCLE_CLEAR_SCREEN_EN
      S_CLEAR: begin
        if (clr_x_r == X_W'(SCREEN_W - 1)) begin
          clr_x_nxt_s = {X_W{1'b0}};
          if (clr_y_r == Y_W'(SCREEN_H - 1)) begin
            clr_y_nxt_s = {Y_W{1'b0}};
            state_nxt_s = S_PLOT;
          end else begin
            clr_y_nxt_s = clr_y_r + Y_W'(1);
          end
        end else begin
          clr_x_nxt_s = clr_x_r + X_W'(1);
        end
      end
`endif
      S_PLOT: begin
        oct_nxt_s = oct_r + 3'd1;
        if (oct_r == 3'd7) begin
          state_nxt_s = S_UPDATE;
        end else begin
          state_nxt_s = S_PLOT;
        end
      end
      S_UPDATE: begin
        ox_nxt_s   = upd_ox_s;
        oy_nxt_s   = upd_oy_s;
        crit_nxt_s = upd_crit_s;
        oct_nxt_s  = 3'd0;
        if (upd_oy_s <= upd_ox_s) begin
          state_nxt_s = S_PLOT;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Octant pixel for the next cycle; odd octants swap ox/oy, octants 2..5 mirror x, 4..7 mirror y
  always_comb begin
    dx_s = oct_nxt_s[0] ? to_c(oy_nxt_s) : to_c(ox_nxt_s);
    dy_s = oct_nxt_s[0] ? to_c(ox_nxt_s) : to_c(oy_nxt_s);
    if ((oct_nxt_s[2] ^ oct_nxt_s[1]) == 1'b1) begin
      px_s = $signed(C_W'(cx_nxt_s)) - dx_s;
    end else begin
      px_s = $signed(C_W'(cx_nxt_s)) + dx_s;
    end
    if (oct_nxt_s[2] == 1'b1) begin
      py_s = $signed(C_W'(cy_nxt_s)) - dy_s;
    end else begin
      py_s = $signed(C_W'(cy_nxt_s)) + dy_s;
    end
    on_screen_s = (px_s >= C_ZERO) && (px_s < C_SW) && (py_s >= C_ZERO) && (py_s < C_SH);
  end

  // Output decode from the next state so the ports can be registered without adding latency
  always_comb begin
    vx_nxt_s   = {X_W{1'b0}};
    vy_nxt_s   = {Y_W{1'b0}};
    vc_nxt_s   = {COLOUR_W{1'b0}};
    plot_nxt_s = 1'b0;
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
`ifdef CIRCLE_CLEAR_SCREEN_EN
      S_CLEAR: begin
        vx_nxt_s   = clr_x_nxt_s;
        vy_nxt_s   = clr_y_nxt_s;
        plot_nxt_s = 1'b1;
        busy_nxt_s = 1'b1;
      end
`endif
      S_PLOT: begin
        vx_nxt_s   = px_s[X_W-1:0];
        vy_nxt_s   = py_s[Y_W-1:0];
        vc_nxt_s   = col_nxt_s;
        plot_nxt_s = on_screen_s;
        busy_nxt_s = 1'b1;
      end
      S_UPDATE: busy_nxt_s = 1'b1;
      S_DONE:   done_nxt_s = 1'b1;
      default:  busy_nxt_s = 1'b0;
    endcase
  end

  // Engine state and latched operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      oct_r   <= 3'd0;
      ox_r    <= O_ZERO;
      oy_r    <= O_ZERO;
      crit_r  <= K_ZERO;
      cx_r    <= {X_W{1'b0}};
      cy_r    <= {Y_W{1'b0}};
      col_r   <= {COLOUR_W{1'b0}};
`ifdef CIRCLE_CLEAR_SCREEN_EN
      clr_x_r <= {X_W{1'b0}};
      clr_y_r <= {Y_W{1'b0}};
`endif
    end else begin
      state_r <= state_nxt_s;
      oct_r   <= oct_nxt_s;
      ox_r    <= ox_nxt_s;
      oy_r    <= oy_nxt_s;
      crit_r  <= crit_nxt_s;
      cx_r    <= cx_nxt_s;
      cy_r    <= cy_nxt_s;
      col_r   <= col_nxt_s;
`ifdef CIRCLE_CLEAR_SCREEN_EN
      clr_x_r <= clr_x_nxt_s;
      clr_y_r <= clr_y_nxt_s;
`endif
    end
  end

  // Registered output ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_x      <= {X_W{1'b0}};
      vga_y      <= {Y_W{1'b0}};
      vga_colour <= {COLOUR_W{1'b0}};
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vga_x      <= vx_nxt_s;
      vga_y      <= vy_nxt_s;
      vga_colour <= vc_nxt_s;
      vga_plot   <= plot_nxt_s;
      busy       <= busy_nxt_s;
      done       <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_circle_plotter_param.sv
// Scoreboard bench for circle_plotter_param: a software midpoint model fills an expected-pixel
// queue, a negedge monitor pops it on every vga_plot; latency, handshake and reset are checked.
module tb_circle_plotter_param;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int R_W = 8;
  localparam int COLOUR_W = 3;
`ifdef CIRCLE_CLEAR_SCREEN_EN
  localparam int CLEAR_CYC = SCREEN_W * SCREEN_H;
  localparam int N_RAND = 1;
`else
  localparam int CLEAR_CYC = 0;
  localparam int N_RAND = 6;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [X_W-1:0] centre_x;
  logic [Y_W-1:0] centre_y;
  logic [R_W-1:0] radius;
  logic [COLOUR_W-1:0] colour;
  logic busy, done, vga_plot;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [COLOUR_W-1:0] vga_colour;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [COLOUR_W-1:0] c;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_p;
  int n_checks = 0;
  int n_fail = 0;

  circle_plotter_param #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .X_W(X_W), .Y_W(Y_W),
    .R_W(R_W), .COLOUR_W(COLOUR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour(colour),
    .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain midpoint circle, table-driven octants, clipped to the screen
  task automatic model(input int cx, input int cy, input int r, input int col, output int iters);
    int sx[8] = '{1, 1, -1, -1, -1, -1, 1, 1};
    int sy[8] = '{1, 1, 1, 1, -1, -1, -1, -1};
    int x, y, d, px, py;
    pix_t p;
`ifdef CIRCLE_CLEAR_SCREEN_EN
    for (int yy = 0; yy < SCREEN_H; yy++)
      for (int xx = 0; xx < SCREEN_W; xx++) begin
        p.x = X_W'(xx); p.y = Y_W'(yy); p.c = '0;
        exp_q.push_back(p);
      end
`endif
    x = r; y = 0; d = 1 - r; iters = 0;
    while (y <= x) begin
      for (int o = 0; o < 8; o++) begin
        px = cx + sx[o] * (((o % 2) == 1) ? y : x);
        py = cy + sy[o] * (((o % 2) == 1) ? x : y);
        if (px >= 0 && px < SCREEN_W && py >= 0 && py < SCREEN_H) begin
          p.x = X_W'(px); p.y = Y_W'(py); p.c = COLOUR_W'(col);
          exp_q.push_back(p);
        end
      end
      iters++;
      y++;
      if (d <= 0) d += 2 * y + 1;
      else begin
        x--;
        d += 2 * (y - x) + 1;
      end
    end
  endtask

  // Monitor: every plot strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && vga_plot) begin
      check("plot_in_range", int'(vga_x < SCREEN_W && vga_y < SCREEN_H), 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_plot: got (%0d,%0d) colour %0d, expected no plot (t=%0t)",
                 vga_x, vga_y, vga_colour, $time);
      end else begin
        mon_p = exp_q.pop_front();
        check("plot_x", vga_x, mon_p.x);
        check("plot_y", vga_y, mon_p.y);
        check("plot_colour", vga_colour, mon_p.c);
      end
    end
  end

  task automatic draw(input int cx, input int cy, input int r, input int col);
    int iters, cyc, budget;
    bit got;
    model(cx, cy, r, col, iters);
    @(negedge clk);
    centre_x = X_W'(cx); centre_y = Y_W'(cy); radius = R_W'(r); colour = COLOUR_W'(col);
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    got = 1'b0;
    budget = CLEAR_CYC + 9 * iters + 20;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    centre_x = X_W'($urandom); centre_y = Y_W'($urandom);
    radius = R_W'($urandom); colour = COLOUR_W'($urandom);
    while (!got && cyc < budget) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
      else cyc++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected %0d", cyc, CLEAR_CYC + 9 * iters);
      exp_q.delete();
    end else begin
      check("done_latency", cyc, CLEAR_CYC + 9 * iters);
      check("queue_drained", exp_q.size(), 0);
      check("busy_in_done", busy, 0);
    end
    repeat (3) begin
      @(negedge clk);
      check("done_held", done, 1);
      check("no_redraw_busy", busy, 0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_fall", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int iters;
    rst = 1'b1; start = 1'b0;
    centre_x = '0; centre_y = '0; radius = '0; colour = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_xy", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
    @(negedge clk);
    rst = 1'b0;

    draw(80, 60, 40, 2);
    draw(10, 10, 0, 5);
    draw(0, 0, 10, 3);
    draw(SCREEN_W - 1, SCREEN_H - 1, 25, 7);
    for (int i = 0; i < N_RAND; i++)
      draw($urandom_range(SCREEN_W - 1, 0), $urandom_range(SCREEN_H - 1, 0),
           $urandom_range(90, 0), $urandom_range(7, 1));

    // Asynchronous reset in the middle of a draw
    model(80, 60, 40, 6, iters);
    @(negedge clk);
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'd6;
    start = 1'b1;
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_plot", vga_plot, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_xyc", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
    exp_q.delete();
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    draw(50, 40, 17, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
